// File: rtl/ram_dq_pkg.sv
// ram_dq_pkg: shared widths, word/address types and sizing helper for the RAM requester
package ram_dq_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int ADDR_BITS = 10;
  localparam int DEF_RSP_DEPTH = 4;
  typedef logic [WORD_WIDTH-1:0] ram_word_t;
  typedef logic [ADDR_BITS-1:0] ram_addr_t;
  function automatic int clog2_depth(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction
endpackage

// File: rtl/ram_dq_rsp_fifo.sv
// ram_dq_rsp_fifo: first-word fall-through response buffer, head reads as zero when empty
module ram_dq_rsp_fifo
  import ram_dq_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = DEF_RSP_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = clog2_depth(DEPTH);
  localparam int CW = clog2_depth(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_pop;
  // Pointer/occupancy update; the caller never pushes into a full buffer
  always_comb begin
    do_pop = pop & ~empty;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = do_pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(do_pop);
  end
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = empty ? '0 : mem_q[rd_q];
  // Storage is not reset; only pointers and occupancy are cleared
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ram_dq_requester.sv
// ram_dq_requester: valid/ready front end for a registered lpm_ram_dq with buffered read returns
module ram_dq_requester
  import ram_dq_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int ADDR_WIDTH = ADDR_BITS,
  parameter int READ_LATENCY = 2,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [WIDTH-1:0]      req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [WIDTH-1:0]      ram_data,
  output logic                  ram_we,
  input  logic [WIDTH-1:0]      ram_q,
  output logic                  busy
);
  localparam int CW = clog2_depth(RSP_DEPTH + 1);
  logic acc, rd_acc, pop, push, fifo_empty, fifo_full;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] fifo_dout;
  // Credits cover reads in the RAM pipe plus buffered responses, so the RAM never stalls
  always_comb begin
    req_ready = (cnt_q < CW'(RSP_DEPTH)) & ~reset;
    acc = req_valid & req_ready;
    rd_acc = acc & ~req_we;
    ram_we = acc & req_we & ~reset;
    ram_address = req_address;
    ram_data = req_data;
    rsp_valid = ~fifo_empty & ~reset;
    rsp_data = fifo_dout;
    pop = rsp_valid & rsp_ready;
    push = tag_q[READ_LATENCY-1] & ~fifo_full;
    busy = (cnt_q != '0) & ~reset;
    tag_d = (tag_q << 1) | READ_LATENCY'(rd_acc);
    cnt_d = cnt_q + CW'(rd_acc) - CW'(pop);
  end
  // Tag pipe marks the cycle ram_q holds read data; reset drops in-flight reads
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end
  ram_dq_rsp_fifo #(.WIDTH(WIDTH), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk(clock),
    .rst(reset),
    .push(push),
    .pop(pop),
    .din(ram_q),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_ram_dq_requester.sv
// tb_ram_dq_requester: scoreboard bench for ram_dq_requester against a registered lpm_ram_dq model
module tb_ram_dq_requester;
  logic clock = 0, reset = 1;
  logic req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [9:0] req_address = '0;
  logic [31:0] req_data = '0;
  logic req_ready, rsp_valid, ram_we, busy;
  logic [31:0] rsp_data, ram_data, ram_q;
  logic [9:0] ram_address;
  logic [31:0] mem [1024];
  logic [31:0] sh [1024];
  logic [9:0] a_r;
  logic [31:0] d_r;
  logic we_r;
  logic [31:0] exp_q [$];
  int n_checks = 0, n_pass = 0, pops = 0, rd_accs = 0;

  ram_dq_requester dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_address(req_address), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_address(ram_address), .ram_data(ram_data), .ram_we(ram_we),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      sh[i] = '0;
    end
    a_r = '0;
    d_r = '0;
    we_r = 0;
    ram_q = '0;
  end

  // lpm_ram_dq: registered address/data/we, write commits in the low phase, registered q
  always @(posedge clock) begin
    a_r <= ram_address;
    d_r <= ram_data;
    we_r <= ram_we;
    ram_q <= mem[a_r];
  end
  always @(negedge clock) if (we_r) mem[a_r] <= d_r;

  // Scoreboard: record accepts, compare every popped response in order
  always @(negedge clock) begin
    if (reset) exp_q.delete();
    else begin
      if (rsp_valid && rsp_ready) begin
        pops++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rsp_unexpected: got %h expected no response", rsp_data);
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (rsp_data !== e) $display("FAIL rsp_data: got %h expected %h", rsp_data, e);
          else n_pass++;
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) sh[req_address] = req_data;
        else begin
          exp_q.push_back(sh[req_address]);
          rd_accs++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [9:0] a, input logic [31:0] d);
    req_valid = v;
    req_we = we;
    req_address = a;
    req_data = d;
  endtask

  task automatic drain_idle(input string name);
    int t = 0;
    drive(0, 0, 0, 0);
    rsp_ready = 1;
    while ((busy || rsp_valid) && t < 40) begin
      step();
      t++;
    end
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL %s_drain: got busy=%b rsp_valid=%b expected 0/0", name, busy, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    step();
    @(negedge clock);
    n_checks++;
    if ({req_ready, rsp_valid, busy, ram_we, rsp_data} !== 36'h0)
      $display("FAIL reset_hold: got rdy/vld/busy/we=%b data=%h expected 0000 data=0", {req_ready, rsp_valid, busy, ram_we}, rsp_data);
    else n_pass++;
    step();
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++;
      if ({req_ready, rsp_valid, busy, ram_we} !== 4'b1000)
        $display("FAIL reset_idle%0d: got %b expected 1000", i, {req_ready, rsp_valid, busy, ram_we});
      else n_pass++;
      step();
    end
  endtask

  task automatic test_write_then_read();
    rsp_ready = 1;
    drive(1, 1, 5, 32'hDEADBEEF);
    step();
    drive(1, 0, 5, 0);
    step();
    drive(0, 0, 0, 0);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clock);
      n_checks++;
      if (rsp_valid !== (k == 4)) $display("FAIL wr_rd_valid_c%0d: got %b expected %b", k, rsp_valid, k == 4);
      else n_pass++;
      if (k == 4) begin
        n_checks++;
        if (rsp_data !== 32'hDEADBEEF) $display("FAIL wr_rd_data: got %h expected deadbeef", rsp_data);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 10'(i), 32'(i * 3));
      step();
    end
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 10'(i), 0);
      @(negedge clock);
      n_checks++;
      if (rsp_valid !== (i >= 3)) $display("FAIL b2b_valid_r%0d: got %b expected %b", i, rsp_valid, i >= 3);
      else n_pass++;
      step();
    end
    drive(0, 0, 0, 0);
    for (int j = 8; j < 12; j++) begin
      @(negedge clock);
      n_checks++;
      if (rsp_valid !== (j <= 10)) $display("FAIL b2b_valid_t%0d: got %b expected %b", j, rsp_valid, j <= 10);
      else n_pass++;
      step();
    end
    n_checks++;
    if (pops - p0 !== 8) $display("FAIL b2b_count: got %0d expected 8", pops - p0);
    else n_pass++;
  endtask

  task automatic test_full();
    int idx = 0, a0, p0, t = 0;
    logic ok;
    rsp_ready = 0;
    a0 = rd_accs;
    p0 = pops;
    for (int c = 0; c < 8; c++) begin
      drive(1, 0, 10'(idx), 0);
      @(negedge clock);
      ok = req_ready;
      step();
      if (ok) idx++;
    end
    @(negedge clock);
    n_checks++;
    if (rd_accs - a0 !== 4 || {req_ready, busy, rsp_valid} !== 3'b011)
      $display("FAIL full_cap: got acc=%0d rdy/busy/vld=%b expected acc=4 011", rd_accs - a0, {req_ready, busy, rsp_valid});
    else n_pass++;
    step();
    rsp_ready = 1;
    @(negedge clock);
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b01) $display("FAIL full_pop_cycle: got %b expected 01", {req_ready, rsp_valid});
    else n_pass++;
    step();
    rsp_ready = 0;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b expected 1", req_ready);
    else n_pass++;
    step();
    idx++;
    rsp_ready = 1;
    while (idx < 6 && t < 30) begin
      drive(1, 0, 10'(idx), 0);
      @(negedge clock);
      ok = req_ready;
      step();
      if (ok) idx++;
      t++;
    end
    drain_idle("full");
    n_checks++;
    if (pops - p0 !== 6 || exp_q.size() != 0) $display("FAIL full_order_count: got pops=%0d left=%0d expected 6 and 0", pops - p0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int a0, p0;
    logic ok;
    rsp_ready = 0;
    p0 = pops;
    drive(1, 0, 1, 0);
    step();
    drive(1, 0, 2, 0);
    step();
    drive(0, 0, 0, 0);
    repeat (4) step();
    drive(1, 0, 3, 0);
    rsp_ready = 1;
    @(negedge clock);
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b11) $display("FAIL simul_both: got %b expected 11", {req_ready, rsp_valid});
    else n_pass++;
    step();
    drive(0, 0, 0, 0);
    rsp_ready = 0;
    repeat (4) step();
    a0 = rd_accs;
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 10'(4 + c), 0);
      @(negedge clock);
      ok = req_ready;
      step();
      if (!ok) c = c;
    end
    n_checks++;
    if (rd_accs - a0 !== 2) $display("FAIL simul_cnt: got %0d extra credits expected 2", rd_accs - a0);
    else n_pass++;
    drain_idle("simul");
    n_checks++;
    if (pops - p0 !== 5 || exp_q.size() != 0) $display("FAIL simul_count: got pops=%0d left=%0d expected 5 and 0", pops - p0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midburst();
    int t = 0;
    rsp_ready = 1;
    drive(1, 1, 5, 32'hDEADBEEF);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 10'(i), 0);
      step();
    end
    drive(1, 1, 9, 32'h0BAD0BAD);
    reset = 1;
    @(negedge clock);
    n_checks++;
    if ({req_ready, rsp_valid, busy, ram_we} !== 4'b0000) $display("FAIL midrst_gate: got %b expected 0000", {req_ready, rsp_valid, busy, ram_we});
    else n_pass++;
    step();
    reset = 0;
    drive(0, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      n_checks++;
      if ({rsp_valid, busy, rsp_data} !== 34'h0) $display("FAIL midrst_stale%0d: got vld=%b busy=%b data=%h expected 0 0 0", c, rsp_valid, busy, rsp_data);
      else n_pass++;
      step();
    end
    drive(1, 0, 5, 0);
    step();
    drive(0, 0, 0, 0);
    @(negedge clock);
    while (!rsp_valid && t < 10) begin
      @(negedge clock);
      t++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF) $display("FAIL midrst_reread: got vld=%b data=%h expected 1 deadbeef", rsp_valid, rsp_data);
    else n_pass++;
    step();
    drain_idle("midrst");
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_back_to_back();
    test_full();
    test_simultaneous();
    test_reset_midburst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
